fp_add_arbiter: RTL and testbench

- Shares one combinational IEEE-754 single-precision adder instance between N_REQ requesters.
- Arbitration is round-robin. Operands and result are registered around the adder.
- Each response is returned over a valid/ready handshake to the granted requester.
- Handles ±0 operands itself, because the adder datapath has no zero handling.

---
 rtl/fp_add_arbiter.sv | 125 ++++++++++++
 tb/tb_fp_add_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter that time-shares one external combinational FP adder
// between N_REQ requesters, with registered operands/result and zero bypass.
module fp_add_arbiter #(
  parameter int EXPONENT = 8,
  parameter int MANTISSA = 23,
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_REQ-1:0]                       req_valid,
  input  logic [N_REQ*(EXPONENT+MANTISSA+1)-1:0] req_a,
  input  logic [N_REQ*(EXPONENT+MANTISSA+1)-1:0] req_b,
  output logic [N_REQ-1:0]                       req_ready,
  output logic [EXPONENT+MANTISSA:0]             add_in1,
  output logic [EXPONENT+MANTISSA:0]             add_in2,
  input  logic [EXPONENT+MANTISSA:0]             add_out,
  output logic [N_REQ-1:0]                       resp_valid,
  input  logic [N_REQ-1:0]                       resp_ready,
  output logic [EXPONENT+MANTISSA:0]             resp_data,
  output logic [ID_W-1:0]                        resp_id,
  output logic                                   busy
);

  localparam int W = EXPONENT + MANTISSA + 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    op_a, op_b;
  logic [ID_W-1:0] g, rr_ptr, winner;
  logic            found;

  // The adder has no zero handling, so signed zeros are resolved here.
  function automatic logic [W-1:0] zero_bypass(input logic [W-1:0] a,
                                               input logic [W-1:0] b,
                                               input logic [W-1:0] sum);
    logic za, zb;
    za = (a[W-2:0] == '0);
    zb = (b[W-2:0] == '0);
    if (za && zb)
      return {a[W-1] & b[W-1], {(W-1){1'b0}}};
    else if (za)
      return b;
    else if (zb)
      return a;
    else
      return sum;
  endfunction

  // Search upward from the slot after the last completed requester.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = '0;
    unique case (state)
      IDLE: begin
        if (found) begin
          req_ready[winner] = 1'b1;
          state_nxt         = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready[g]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      g          <= '0;
      rr_ptr     <= ID_W'(N_REQ - 1);
      resp_valid <= '0;
      resp_id    <= '0;
      resp_data  <= '0;
    end else begin
      state <= state_nxt;
      unique case (state)
        // grant: operands are captured once and isolated from req_a/req_b
        IDLE: begin
          if (found) begin
            op_a <= req_a[winner*W +: W];
            op_b <= req_b[winner*W +: W];
            g    <= winner;
          end
        end
        // execute: adder result (or bypass) is registered into resp_data
        EXEC: begin
          resp_data  <= zero_bypass(op_a, op_b, add_out);
          resp_valid <= {{(N_REQ-1){1'b0}}, 1'b1} << g;
          resp_id    <= g;
        end
        // respond: hold until the owning requester accepts
        RESP: begin
          if (resp_ready[g]) begin
            resp_valid <= '0;
            rr_ptr     <= g;
          end
        end
        default: ;
      endcase
    end
  end

  assign add_in1 = op_a;
  assign add_in2 = op_b;
  assign busy    = (state != IDLE);

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed + randomized bench for fp_add_arbiter with a behavioural adder
// stub and a reference model of grant order and result selection.
module tb_fp_add_arbiter;

  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   add_in1, add_in2, add_out;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready = '0;
  logic [W-1:0]   resp_data;
  logic [1:0]     resp_id;
  logic           busy;

  int checks = 0;
  int errors = 0;
  int last_served = N - 1;
  logic [W-1:0] sa[N];
  logic [W-1:0] sb[N];

  fp_add_arbiter #(.EXPONENT(8), .MANTISSA(23), .N_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .add_in1(add_in1), .add_in2(add_in2), .add_out(add_out),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // Values are handled as signed fixed point scaled by 256 (exact for the operand set used).
  function automatic longint fdec(input logic [31:0] x);
    longint m;
    int sh;
    m  = longint'({1'b1, x[22:0]});
    sh = int'(x[30:23]) - 142;
    m  = (sh >= 0) ? (m <<< sh) : (m >>> (-sh));
    return x[31] ? -m : m;
  endfunction

  function automatic logic [31:0] fenc(input longint s);
    longint mag;
    int p;
    logic [31:0] r;
    logic [7:0] e;
    logic [22:0] mt;
    if (s == 0) return 32'h0;
    mag = (s < 0) ? -s : s;
    p = 0;
    for (int i = 0; i < 40; i++) if ((mag >>> i) != 0) p = i;
    e  = 8'(127 + p - 8);
    mt = (p >= 23) ? 23'(mag >>> (p - 23)) : 23'(mag <<< (23 - p));
    r  = {(s < 0), e, mt};
    return r;
  endfunction

  // Shared adder stand-in: deliberately garbage when an operand is zero.
  always_comb begin
    if (add_in1[30:0] == '0 || add_in2[30:0] == '0) add_out = 32'h7FC0_0BAD;
    else add_out = fenc(fdec(add_in1) + fdec(add_in2));
  end

  function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
    bit za, zb;
    za = (a[30:0] == 0);
    zb = (b[30:0] == 0);
    if (za && zb) return (a[31] && b[31]) ? 32'h8000_0000 : 32'h0;
    if (za) return b;
    if (zb) return a;
    return fenc(fdec(a) + fdec(b));
  endfunction

  function automatic int pick(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++)
      if (mask[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  function automatic logic [31:0] rand_op();
    int r;
    longint s;
    r = int'($urandom_range(0, 9));
    if (r == 0) return 32'h0;
    if (r == 1) return 32'h8000_0000;
    s = longint'($urandom_range(1, 4000));
    if ($urandom_range(0, 1) == 1) s = -s;
    return fenc(s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = sa[i];
      req_b[i*W +: W] = sb[i];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; after grant req_valid becomes after_mask.
  task automatic transact(input logic [N-1:0] mask, input logic [N-1:0] after_mask,
                          input int hold, input bit mutate);
    int w;
    logic [31:0] ea, eb, er;
    req_valid = mask;
    pack();
    #1;
    w = pick(mask, last_served);
    chk("grant", 32'(req_ready), 32'(1 << w));
    chk("idle_busy", 32'(busy), 32'd0);
    ea = sa[w];
    eb = sb[w];
    er = ref_add(ea, eb);
    step();
    req_valid = after_mask;
    if (mutate) begin
      sa[w] = sa[w] ^ 32'h0040_0000;
      sb[w] = 32'h4120_0000;
      pack();
    end
    #1;
    chk("exec_busy", 32'(busy), 32'd1);
    chk("exec_ready", 32'(req_ready), 32'd0);
    chk("add_in1", add_in1, ea);
    chk("add_in2", add_in2, eb);
    step();
    chk("resp_valid", 32'(resp_valid), 32'(1 << w));
    chk("resp_id", 32'(resp_id), 32'(w));
    chk("resp_data", resp_data, er);
    resp_ready = ~N'(1 << w);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 32'(resp_valid), 32'(1 << w));
      chk("hold_data", resp_data, er);
      chk("hold_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = N'(1 << w);
    step();
    resp_ready = '0;
    #1;
    chk("release_valid", 32'(resp_valid), 32'd0);
    chk("release_busy", 32'(busy), 32'd0);
    last_served = w;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin sa[i] = 32'h0; sb[i] = 32'h0; end
    rst = 1'b1;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_id", 32'(resp_id), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_add_in1", add_in1, 32'd0);
    step();
    rst = 1'b0;
    step();

    // 1.5 + 1.5 on requester 2
    sa[2] = 32'h3FC0_0000; sb[2] = 32'h3FC0_0000;
    chk("ref_sanity_sum", ref_add(sa[2], sb[2]), 32'h4040_0000);
    transact(4'b0100, 4'b0000, 1, 1'b0);

    // backpressure on requester 1 while requester 0 waits
    sa[1] = 32'h3F80_0000; sb[1] = 32'h4000_0000;
    sa[0] = 32'h4100_0000; sb[0] = 32'hC000_0000;
    transact(4'b0010, 4'b0001, 5, 1'b0);
    transact(4'b0001, 4'b0000, 0, 1'b0);

    // zero bypass
    sa[3] = 32'h0000_0000; sb[3] = 32'h4000_0000;
    transact(4'b1000, 4'b0000, 0, 1'b0);
    chk("zb_pos", resp_data, 32'h4000_0000);
    sa[3] = 32'h8000_0000; sb[3] = 32'h8000_0000;
    transact(4'b1000, 4'b0000, 0, 1'b0);
    chk("zb_negneg", resp_data, 32'h8000_0000);
    sa[3] = 32'h8000_0000; sb[3] = 32'h0000_0000;
    transact(4'b1000, 4'b0000, 0, 1'b0);
    chk("zb_negpos", resp_data, 32'h0000_0000);

    // operand isolation
    sa[2] = 32'h4040_0000; sb[2] = 32'h3F80_0000;
    transact(4'b0100, 4'b0000, 0, 1'b1);
    chk("isolation", resp_data, 32'h4080_0000);

    // randomized traffic
    for (int t = 0; t < 30; t++) begin
      logic [N-1:0] m;
      m = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin sa[i] = rand_op(); sb[i] = rand_op(); end
      transact(m, N'($urandom_range(0, (1 << N) - 1)) & m, int'($urandom_range(0, 3)),
               1'($urandom_range(0, 1)));
    end
    req_valid = '0;
    step();

    // reset mid-operation
    transact(4'b0000 | N'(1 << ((last_served + 2) % N)), 4'b0000, 0, 1'b0);
    req_valid = 4'b0010;
    step();
    req_valid = 4'b0000;
    #3;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(resp_valid), 32'd0);
    step();
    step();
    rst = 1'b0;
    last_served = N - 1;
    for (int i = 0; i < N; i++) begin sa[i] = rand_op(); sb[i] = rand_op(); end
    transact(4'b1001, 4'b1000, 0, 1'b0);
    transact(4'b1000, 4'b0000, 0, 1'b0);

    // continuous requests from reset with resp_ready high
    rst = 1'b1;
    step();
    rst = 1'b0;
    last_served = N - 1;
    req_valid = '1;
    resp_ready = '1;
    for (int c = 0; c < 15; c++) begin
      #1;
      if (c % 3 == 0) begin
        chk("rotate_grant", 32'(req_ready), 32'(1 << pick('1, last_served)));
        last_served = pick('1, last_served);
      end else begin
        chk("rotate_idle", 32'(req_ready), 32'd0);
      end
      chk("resp_onehot", 32'($countones(resp_valid) <= 1), 32'd1);
      if (c == 14) req_valid = '0;
      step();
    end
    resp_ready = '0;
    #1;
    chk("final_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
